// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 5-row x 4-column active-low key matrix one row at a time.
//   Presses are debounced across whole scan frames. Each accepted key
//   produces exactly one single-cycle strobe.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   col_n[3:0]   matrix columns, active-low, asynchronous to clk
//   row_n[4:0]   row drive, active-low, one row low at a time
//   b_0..b_f     hex key strobes (codes 0-15)
//   b_load       code 16 strobe
//   b_storeinc   code 17 strobe
//   b_dec        code 18 strobe
//   b_aux        code 19 strobe
//   key_valid    pulses together with any strobe
//   key_code     code of the last accepted key, held between presses
//
// Debounce FSM (advances only at frame end)
//   state  | meaning
//   S_IDLE | no key pending; waiting for a single-key frame
//   S_CAND | candidate key seen in cnt consecutive single-key frames
//   S_HELD | key accepted; cnt counts consecutive empty frames to release
module keypad_scanner #(
  parameter int SCAN_DIV        = 1024,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [4:0] row_n,
  output logic       b_0,
  output logic       b_1,
  output logic       b_2,
  output logic       b_3,
  output logic       b_4,
  output logic       b_5,
  output logic       b_6,
  output logic       b_7,
  output logic       b_8,
  output logic       b_9,
  output logic       b_a,
  output logic       b_b,
  output logic       b_c,
  output logic       b_d,
  output logic       b_e,
  output logic       b_f,
  output logic       b_load,
  output logic       b_storeinc,
  output logic       b_dec,
  output logic       b_aux,
  output logic       key_valid,
  output logic [4:0] key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // cnt never exceeds DEBOUNCE_FRAMES-1, so this width saturates by construction.
  localparam int CW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] D_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAND = 2'd1,
    S_HELD = 2'd2
  } state_t;

  // Column synchronizer; resets to "all released".
  logic [3:0] col_meta_q, col_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  // Scan counters
  logic [DW-1:0] d_q, d_d;
  logic [2:0]    r_q, r_d;
  logic          dwell_end, frame_end;

  assign dwell_end = (d_q == D_LAST);
  assign frame_end = dwell_end && (r_q == 3'd4);

  always_comb begin
    d_d = d_q + DW'(1);
    r_d = r_q;
    if (dwell_end) begin
      d_d = '0;
      r_d = (r_q == 3'd4) ? 3'd0 : r_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      r_q <= '0;
    end else begin
      d_q <= d_d;
      r_q <= r_d;
    end
  end

  assign row_n = ~(5'd1 << r_q);

  // Snapshot. snap_full merges the row being sampled this cycle so the
  // frame-end decision sees row 4 without waiting another cycle.
  logic [19:0] snap_q, snap_d, snap_full, row_bits;

  always_comb begin
    row_bits  = {16'd0, ~col_sync_q} << {r_q, 2'b00};
    snap_full = snap_q | row_bits;
    snap_d    = snap_q;
    if (frame_end)      snap_d = '0;
    else if (dwell_end) snap_d = snap_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) snap_q <= '0;
    else     snap_q <= snap_d;
  end

  // Frame classification
  logic       is_none, is_single;
  logic [4:0] single_code;

  always_comb begin
    is_none     = (snap_full == 20'd0);
    // A non-zero vector with no second bit set is one-hot.
    is_single   = !is_none && ((snap_full & (snap_full - 20'd1)) == 20'd0);
    single_code = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (snap_full[i]) single_code = 5'(i);
    end
  end

  // Debounce FSM with registered strobes
  state_t        state_q;
  logic [4:0]    code_q;
  logic [CW-1:0] cnt_q;
  logic [19:0]   stb_q;
  logic          key_valid_q;
  logic [4:0]    key_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      cnt_q       <= '0;
      stb_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      stb_q       <= '0;
      key_valid_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          S_IDLE: begin
            if (is_single) begin
              state_q <= S_CAND;
              code_q  <= single_code;
              cnt_q   <= CNT_ONE;
            end
          end
          S_CAND: begin
            if (is_single && (single_code == code_q)) begin
              if (cnt_q == CNT_LAST) begin
                stb_q       <= 20'd1 << code_q;
                key_valid_q <= 1'b1;
                key_code_q  <= code_q;
                state_q     <= S_HELD;
                cnt_q       <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end else if (is_single) begin
              code_q <= single_code;
              cnt_q  <= CNT_ONE;
            end else begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end
          end
          S_HELD: begin
            if (is_none) begin
              if (cnt_q == CNT_LAST) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end else begin
              // Any key activity restarts the release count.
              cnt_q <= '0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign {b_aux, b_dec, b_storeinc, b_load,
          b_f, b_e, b_d, b_c, b_b, b_a, b_9, b_8,
          b_7, b_6, b_5, b_4, b_3, b_2, b_1, b_0} = stb_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix model driven by a per-frame set of
// pressed keys, a frame-level run-length reference model, a table of
// scripted segments, a bounce sequence, random segments and a mid-candidate
// reset.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_n;
  logic [4:0] row_n;
  logic b_0, b_1, b_2, b_3, b_4, b_5, b_6, b_7;
  logic b_8, b_9, b_a, b_b, b_c, b_d, b_e, b_f;
  logic b_load, b_storeinc, b_dec, b_aux;
  logic       key_valid;
  logic [4:0] key_code;
  logic [19:0] stb_obs;
  logic [19:0] pressed = '0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
    .b_0(b_0), .b_1(b_1), .b_2(b_2), .b_3(b_3),
    .b_4(b_4), .b_5(b_5), .b_6(b_6), .b_7(b_7),
    .b_8(b_8), .b_9(b_9), .b_a(b_a), .b_b(b_b),
    .b_c(b_c), .b_d(b_d), .b_e(b_e), .b_f(b_f),
    .b_load(b_load), .b_storeinc(b_storeinc), .b_dec(b_dec), .b_aux(b_aux),
    .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  assign stb_obs = {b_aux, b_dec, b_storeinc, b_load,
                    b_f, b_e, b_d, b_c, b_b, b_a, b_9, b_8,
                    b_7, b_6, b_5, b_4, b_3, b_2, b_1, b_0};

  // Physical matrix: a pressed key shorts its column to its row line.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 5; r++)
      if (row_n[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col_n[c] = 1'b0;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int seg_pulses = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model in frame terms: a key is accepted after DF consecutive
  // identical single-key frames; once accepted, nothing more is accepted
  // until DF consecutive empty frames have been seen.
  bit          m_locked;
  int          m_none_run;
  int          m_key;
  int          m_len;
  logic [4:0]  m_code;
  logic [19:0] m_pend;

  task automatic model_reset();
    m_locked = 0; m_none_run = 0; m_key = 0; m_len = 0;
    m_code = '0; m_pend = '0;
  endtask

  task automatic model_frame(input logic [19:0] p);
    int n;
    int k;
    n = $countones(p);
    k = 0;
    for (int i = 0; i < 20; i++) if (p[i]) k = i;
    if (m_locked) begin
      if (n == 0) begin
        m_none_run++;
        if (m_none_run == DF) begin
          m_locked = 0;
          m_len = 0;
        end
      end else begin
        m_none_run = 0;
      end
    end else if (n == 1) begin
      if (m_len > 0 && k == m_key) m_len++;
      else begin
        m_key = k;
        m_len = 1;
      end
      if (m_len == DF) begin
        m_pend = 20'd1 << k;
        m_code = 5'(k);
        m_locked = 1;
        m_none_run = 0;
        m_len = 0;
      end
    end else begin
      m_len = 0;
    end
  endtask

  // Entered just after a rising edge at the start of a frame (d=0, r=0).
  task automatic run_frame(input logic [19:0] p, input int ncyc);
    logic [4:0]  er;
    logic [19:0] es;
    pressed = p;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      er = ~(5'd1 << (i / SD));
      es = (i == 0) ? m_pend : 20'd0;
      cmp("row_n", 32'(row_n), 32'(er));
      cmp("strobes", 32'(stb_obs), 32'(es));
      cmp("key_valid", 32'(key_valid), 32'(es != 20'd0));
      cmp("key_code", 32'(key_code), 32'(m_code));
      if (key_valid) seg_pulses++;
      if (i == 0) m_pend = '0;
      if (i == 5*SD-1) model_frame(p);
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [19:0] keys;
    int          frames;
    int          exp_pulses;
    logic [4:0]  exp_code;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{20'h00000, 2,  0, 5'd0};
    tbl[1]  = '{20'h00400, 10, 1, 5'd10};  // key A held
    tbl[2]  = '{20'h00000, 3,  0, 5'd10};
    tbl[3]  = '{20'h00088, 8,  0, 5'd10};  // keys 3+7 together
    tbl[4]  = '{20'h00008, 4,  1, 5'd3};   // key 7 released
    tbl[5]  = '{20'h00000, 3,  0, 5'd3};
    tbl[6]  = '{20'h10000, 4,  1, 5'd16};  // load
    tbl[7]  = '{20'h00000, 2,  0, 5'd16};  // release too short
    tbl[8]  = '{20'h10000, 5,  0, 5'd16};
    tbl[9]  = '{20'h00000, 3,  0, 5'd16};  // full release
    tbl[10] = '{20'h10000, 4,  1, 5'd16};
    tbl[11] = '{20'h00000, 3,  0, 5'd16};

    model_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset row_n", 32'(row_n), 32'h1E);
    cmp("reset strobes", 32'(stb_obs), 32'h0);
    cmp("reset key_valid", 32'(key_valid), 32'h0);
    cmp("reset key_code", 32'(key_code), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[v]) begin
      seg_pulses = 0;
      for (int f = 0; f < tbl[v].frames; f++) run_frame(tbl[v].keys, 5*SD);
      cmp($sformatf("tbl[%0d] pulses", v), 32'(seg_pulses), 32'(tbl[v].exp_pulses));
      cmp($sformatf("tbl[%0d] key_code", v), 32'(key_code), 32'(tbl[v].exp_code));
    end

    // Key 5 bouncing frame by frame
    seg_pulses = 0;
    for (int f = 0; f < 12; f++) run_frame((f % 2 == 0) ? 20'h00020 : 20'h00000, 5*SD);
    for (int f = 0; f < 3; f++) run_frame(20'h00000, 5*SD);
    cmp("bounce pulses", 32'(seg_pulses), 32'h0);

    // Random segments of none / single / multi frames
    for (int s = 0; s < 50; s++) begin
      logic [19:0] p;
      int kind;
      int len;
      int k1;
      int k2;
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      k1   = $urandom_range(0, 19);
      k2   = (k1 + $urandom_range(1, 19)) % 20;
      p = '0;
      if (kind == 1 || kind == 2) p[k1] = 1'b1;
      else if (kind == 3) begin
        p[k1] = 1'b1;
        p[k2] = 1'b1;
      end
      for (int f = 0; f < len; f++) run_frame(p, 5*SD);
    end

    // Reset in the middle of a candidate for key 18
    for (int f = 0; f < DF; f++) run_frame(20'h00000, 5*SD);
    run_frame(20'h40000, 5*SD);
    run_frame(20'h40000, 5*SD);
    run_frame(20'h40000, 7);
    #2 rst = 1'b1;
    #1;
    cmp("async reset row_n", 32'(row_n), 32'h1E);
    cmp("async reset strobes", 32'(stb_obs), 32'h0);
    cmp("async reset key_code", 32'(key_code), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    seg_pulses = 0;
    for (int f = 0; f < 3; f++) run_frame(20'h40000, 5*SD);
    cmp("post-reset early pulses", 32'(seg_pulses), 32'h0);
    for (int f = 0; f < 3; f++) run_frame(20'h40000, 5*SD);
    cmp("post-reset pulses", 32'(seg_pulses), 32'h1);
    cmp("post-reset key_code", 32'(key_code), 32'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
